// File: rtl/mul_sched_pkg.sv
// Shared types and width helpers for the multi-flux multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } flux_state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_CFG  = 2'd1,
        OP_MUL  = 2'd2
    } op_e;

    // Remaining-products counter holds ext_size squared.
    function automatic int unsigned cnt_width(input int unsigned dw);
        return 2 * dw;
    endfunction

    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_flux_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned TW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [TW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [TW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        int unsigned j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!valid_o && req_i[TW'(j)]) begin
                valid_o         = 1'b1;
                gnt_o[TW'(j)]   = 1'b1;
                idx_o           = TW'(j);
            end
        end
    end

endmodule

// File: rtl/mul_flux_scheduler.sv
// Round-robin CFG/MUL scheduler across FLUX interleaved multiplier fluxes.
// Optional MUL_SCHED_STICKY_EN keeps priority on a flux for up to MAX_BURST MULs.
module mul_flux_scheduler
    import mul_sched_pkg::*;
#(
    parameter int unsigned FLUX           = 2,
    parameter int unsigned DATA_WIDTH_EXT = 7,
    parameter int unsigned TAG_WIDTH      = tag_width(FLUX),
    parameter int unsigned CNT_WIDTH      = cnt_width(DATA_WIDTH_EXT),
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FLUX-1:0]           opa_empty,
    input  logic [FLUX-1:0]           opb_empty,
    input  logic [FLUX-1:0]           ext_empty,
    input  logic [FLUX-1:0]           prod_full,
    input  logic [DATA_WIDTH_EXT-1:0] ext_size,
    output logic [FLUX-1:0]           read_opa,
    output logic [FLUX-1:0]           read_opb,
    output logic [FLUX-1:0]           read_ext,
    output logic                      write_prod,
    output logic                      grant_valid,
    output logic [TAG_WIDTH-1:0]      grant_tag,
    output logic                      cfg_load,
    output logic                      mul_en,
    output logic                      block_last
);

    if (FLUX < 1 || MAX_BURST < 1) begin : g_param_check
        $error("mul_flux_scheduler: FLUX and MAX_BURST must be >= 1");
    end

    flux_state_e            state_q [FLUX];
    flux_state_e            state_d [FLUX];
    logic [CNT_WIDTH-1:0]   rem_q   [FLUX];
    logic [CNT_WIDTH-1:0]   rem_d   [FLUX];
    logic [TAG_WIDTH-1:0]   ptr_q, ptr_d;

    logic [FLUX-1:0]        req_c;
    logic [FLUX-1:0]        gnt_oh_c;
    logic [TAG_WIDTH-1:0]   gnt_idx_c;
    logic [TAG_WIDTH-1:0]   nxt_ptr_c;
    logic                   gnt_any_c;
    logic                   last_c;
    op_e                    op_c;

`ifdef MUL_SCHED_STICKY_EN
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    logic [BURST_W-1:0]     burst_q, burst_d, burst_cnt_c;
`endif

    // IDLE fluxes want a coefficient/size pair; WORK fluxes want opA and product space.
    always_comb begin
        req_c = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (state_q[i] == IDLE) begin
                req_c[i] = !opb_empty[i] && !ext_empty[i];
            end else begin
                req_c[i] = !opa_empty[i] && !prod_full[i];
            end
        end
    end

    rr_arbiter #(
        .N  (FLUX),
        .TW (TAG_WIDTH)
    ) u_arb (
        .req_i   (req_c),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_oh_c),
        .idx_o   (gnt_idx_c),
        .valid_o (gnt_any_c)
    );

    always_comb begin
        op_c      = OP_NONE;
        last_c    = 1'b0;
        nxt_ptr_c = (32'(gnt_idx_c) == FLUX - 1) ? '0 : gnt_idx_c + TAG_WIDTH'(1);
        if (gnt_any_c) begin
            op_c   = (state_q[gnt_idx_c] == IDLE) ? OP_CFG : OP_MUL;
            last_c = (op_c == OP_MUL) && (rem_q[gnt_idx_c] == CNT_WIDTH'(1));
        end
    end

    assign read_opb    = (op_c == OP_CFG) ? gnt_oh_c : '0;
    assign read_ext    = (op_c == OP_CFG) ? gnt_oh_c : '0;
    assign read_opa    = (op_c == OP_MUL) ? gnt_oh_c : '0;
    assign cfg_load    = (op_c == OP_CFG);
    assign mul_en      = (op_c == OP_MUL);
    assign write_prod  = (op_c == OP_MUL);
    assign grant_valid = gnt_any_c;
    assign grant_tag   = gnt_any_c ? gnt_idx_c : '0;
    assign block_last  = last_c;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        unique case (op_c)
            OP_CFG: begin
                rem_d[gnt_idx_c] = CNT_WIDTH'(ext_size) * CNT_WIDTH'(ext_size);
                if (ext_size != '0) begin
                    state_d[gnt_idx_c] = WORK;
                end
            end
            OP_MUL: begin
                rem_d[gnt_idx_c] = rem_q[gnt_idx_c] - CNT_WIDTH'(1);
                if (last_c) begin
                    state_d[gnt_idx_c] = IDLE;
                end
            end
            default: ;
        endcase
`ifdef MUL_SCHED_STICKY_EN
        // A nonzero burst count always belongs to the flux the pointer is parked on.
        burst_d     = burst_q;
        burst_cnt_c = '0;
        if (op_c == OP_MUL && !last_c) begin
            burst_cnt_c = ((gnt_idx_c == ptr_q) ? burst_q : '0) + BURST_W'(1);
            if (burst_cnt_c >= BURST_W'(MAX_BURST)) begin
                ptr_d   = nxt_ptr_c;
                burst_d = '0;
            end else begin
                ptr_d   = gnt_idx_c;
                burst_d = burst_cnt_c;
            end
        end else if (gnt_any_c) begin
            ptr_d   = nxt_ptr_c;
            burst_d = '0;
        end
`else
        if (gnt_any_c) begin
            ptr_d = nxt_ptr_c;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
            end
            ptr_q <= '0;
`ifdef MUL_SCHED_STICKY_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
`ifdef MUL_SCHED_STICKY_EN
            burst_q <= burst_d;
`endif
        end
    end

endmodule

// File: tb/tb_mul_flux_scheduler.sv
// Scoreboard bench for mul_flux_scheduler with FIFO occupancy models per flux.
module tb_mul_flux_scheduler;

    localparam int OP_CFG_I = 1;
    localparam int OP_MUL_I = 2;

    typedef struct {
        int tag;
        int op;
        bit last;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] opa_empty, opb_empty, ext_empty, prod_full;
    logic [6:0] ext_size;
    logic [1:0] read_opa, read_opb, read_ext;
    logic       write_prod, grant_valid, cfg_load, mul_en, block_last;
    logic [0:0] grant_tag;

    int         opa_cnt  [2];
    int         opb_cnt  [2];
    int         ext_rd   [2];
    int         ext_wr   [2];
    int         prod_cnt [2];
    logic [6:0] ext_mem  [2][8];

    exp_t       exp_q[$];
    int         checks;
    int         errors;

    mul_flux_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .opa_empty   (opa_empty),
        .opb_empty   (opb_empty),
        .ext_empty   (ext_empty),
        .prod_full   (prod_full),
        .ext_size    (ext_size),
        .read_opa    (read_opa),
        .read_opb    (read_opb),
        .read_ext    (read_ext),
        .write_prod  (write_prod),
        .grant_valid (grant_valid),
        .grant_tag   (grant_tag),
        .cfg_load    (cfg_load),
        .mul_en      (mul_en),
        .block_last  (block_last)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            opa_empty[i] = (opa_cnt[i] == 0);
            opb_empty[i] = (opb_cnt[i] == 0);
            ext_empty[i] = (ext_rd[i] == ext_wr[i]);
        end
        ext_size = ext_mem[grant_tag][ext_rd[grant_tag] % 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push(input int tag, input int op, input bit last);
        exp_t e;
        e.tag  = tag;
        e.op   = op;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic load(input int f, input int size, input int n_opa);
        opb_cnt[f]++;
        ext_mem[f][ext_wr[f] % 8] = 7'(size);
        ext_wr[f]++;
        opa_cnt[f] += n_opa;
    endtask

    // Compare at the falling edge, then retire FIFO reads just after the rising edge.
    task automatic step();
        logic [1:0] ra, rb, re, oh;
        logic       wp;
        int         t, obs_op;
        exp_t       e;
        @(negedge clk);
        ra     = read_opa;
        rb     = read_opb;
        re     = read_ext;
        wp     = write_prod;
        t      = int'(grant_tag);
        obs_op = cfg_load ? OP_CFG_I : (mul_en ? OP_MUL_I : 0);
        if (grant_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexp_grant", 32'(grant_valid), 32'd0);
            end else begin
                e  = exp_q.pop_front();
                oh = 2'(1 << e.tag);
                chk("tag",      32'(grant_tag),  32'(e.tag));
                chk("op",       32'(obs_op),     32'(e.op));
                chk("last",     32'(block_last), 32'(e.last));
                chk("rd_opb",   32'(read_opb),   32'((e.op == OP_CFG_I) ? oh : 2'b00));
                chk("rd_ext",   32'(read_ext),   32'((e.op == OP_CFG_I) ? oh : 2'b00));
                chk("rd_opa",   32'(read_opa),   32'((e.op == OP_MUL_I) ? oh : 2'b00));
                chk("wr_prod",  32'(write_prod), 32'(e.op == OP_MUL_I));
            end
        end else begin
            chk("idle_outs", 32'({read_opa, read_opb, read_ext, write_prod,
                                  cfg_load, mul_en, block_last, grant_tag}), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (ra[i]) opa_cnt[i]--;
            if (rb[i]) opb_cnt[i]--;
            if (re[i]) ext_rd[i]++;
        end
        if (wp) prod_cnt[t]++;
    endtask

    task automatic run_all(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        prod_full = 2'b00;
        for (int i = 0; i < 2; i++) begin
            opa_cnt[i]  = 0;
            opb_cnt[i]  = 0;
            ext_rd[i]   = 0;
            ext_wr[i]   = 0;
            prod_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq_len [6];
        int done    [2];
        clk    = 1'b0;
        rst    = 1'b0;
        checks = 0;
        errors = 0;
        prod_full = 2'b00;
        for (int i = 0; i < 2; i++) begin
            opa_cnt[i] = 0; opb_cnt[i] = 0; ext_rd[i] = 0; ext_wr[i] = 0; prod_cnt[i] = 0;
            for (int k = 0; k < 8; k++) ext_mem[i][k] = 7'd0;
        end
        #1;
        chk("rst_gv",   32'(grant_valid), 32'd0);
        chk("rst_outs", 32'({read_opa, read_opb, read_ext, write_prod,
                             cfg_load, mul_en, block_last, grant_tag}), 32'd0);

        // Reset, idle, then async reset while a MUL is pending.
        do_reset();
        idle(10);
        load(0, 2, 0);
        push(0, OP_CFG_I, 1'b0);
        run_all(10);
        opa_cnt[0] = 1;
        #1;
        chk("pre_rst_mul", 32'(mul_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_gv",  32'(grant_valid), 32'd0);
        chk("async_rst_mul", 32'(mul_en),      32'd0);
        opa_cnt[0] = 0;

        // Single flux, ext_size=2.
        do_reset();
        load(0, 2, 4);
        push(0, OP_CFG_I, 1'b0);
        for (int k = 0; k < 4; k++) push(0, OP_MUL_I, k == 3);
        run_all(20);
        chk("t2_prod0", 32'(prod_cnt[0]), 32'd4);
        opa_cnt[0] = 1;
        idle(3);
        chk("t2_idle_opa", 32'(opa_cnt[0]), 32'd1);

        // Two fluxes alternate.
        do_reset();
        load(0, 2, 4);
        load(1, 2, 4);
        push(0, OP_CFG_I, 1'b0);
        push(1, OP_CFG_I, 1'b0);
        for (int k = 0; k < 4; k++) begin
            push(0, OP_MUL_I, k == 3);
            push(1, OP_MUL_I, k == 3);
        end
        run_all(30);
        chk("t3_prod0", 32'(prod_cnt[0]), 32'd4);
        chk("t3_prod1", 32'(prod_cnt[1]), 32'd4);

        // prod_full blocks only flux1.
        do_reset();
        prod_full = 2'b10;
        load(0, 2, 4);
        load(1, 2, 4);
        push(0, OP_CFG_I, 1'b0);
        push(1, OP_CFG_I, 1'b0);
        for (int k = 0; k < 4; k++) push(0, OP_MUL_I, k == 3);
        run_all(20);
        idle(3);
        chk("t4_held_opa1", 32'(opa_cnt[1]), 32'd4);
        prod_full = 2'b00;
        for (int k = 0; k < 4; k++) push(1, OP_MUL_I, k == 3);
        step();
        chk("t4_resume", 32'(exp_q.size()), 32'd3);
        run_all(10);
        chk("t4_prod1", 32'(prod_cnt[1]), 32'd4);

        // ext_size=0 configures nothing; next pair accepted.
        do_reset();
        load(0, 0, 0);
        load(0, 1, 1);
        push(0, OP_CFG_I, 1'b0);
        push(0, OP_CFG_I, 1'b0);
        push(0, OP_MUL_I, 1'b1);
        run_all(10);
        chk("t5_prod0", 32'(prod_cnt[0]), 32'd1);
        idle(2);

        // ext_size=3 on both fluxes: rotation or sticky bursts.
        do_reset();
        load(0, 3, 9);
        load(1, 3, 9);
        push(0, OP_CFG_I, 1'b0);
        push(1, OP_CFG_I, 1'b0);
`ifdef MUL_SCHED_STICKY_EN
        seq_len = '{4, 4, 4, 4, 1, 1};
        done    = '{0, 0};
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < seq_len[s]; k++) begin
                done[s % 2]++;
                push(s % 2, OP_MUL_I, done[s % 2] == 9);
            end
        end
`else
        seq_len = '{0, 0, 0, 0, 0, 0};
        done    = '{0, 0};
        for (int k = 0; k < 9; k++) begin
            push(0, OP_MUL_I, k == 8);
            push(1, OP_MUL_I, k == 8);
        end
`endif
        run_all(40);
        chk("t6_prod0", 32'(prod_cnt[0]), 32'd9);
        chk("t6_prod1", 32'(prod_cnt[1]), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
